ref_row_writer: RTL and testbench

REF_ROW_WRITER -- requirements
Module: ref_row_writer

---
 rtl/intra_pred_pkg.sv | 13 +
 rtl/ref_row_writer_if.sv | 10 +
 rtl/ref_row_writer.sv | 121 ++++++++++++
 tb/tb_ref_row_writer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_pred_pkg.sv
// Shared intra-prediction definitions used by the top-reference row writer
// and the top-reference capture buffer.
package intra_pred_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2
  } row_state_e;

  localparam int ROW_LEN    = 8;
  localparam int IDX_W      = 3;
  localparam int DEF_ADDR_W = 9;
endpackage

// File: rtl/ref_row_writer_if.sv
// Byte write bus into the top-reference line memory (valid/ready).
interface ref_row_writer_if #(parameter int ADDR_W = 9);
  logic              WR_VALID;
  logic              WR_READY;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;

  modport master (output WR_VALID, WR_ADDR, WR_DATA, input WR_READY);
  modport slave  (input WR_VALID, WR_ADDR, WR_DATA, output WR_READY);
endinterface

// File: rtl/ref_row_writer.sv
// Writes the bottom row of a reconstructed 8x8 block into the top-reference
// line memory, one byte per accepted transfer, then pulses DONE.
module ref_row_writer
  import intra_pred_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              START,
  input  logic [ADDR_W-4:0] BLK_X,
  input  logic [7:0]        RECON0,
  input  logic [7:0]        RECON1,
  input  logic [7:0]        RECON2,
  input  logic [7:0]        RECON3,
  input  logic [7:0]        RECON4,
  input  logic [7:0]        RECON5,
  input  logic [7:0]        RECON6,
  input  logic [7:0]        RECON7,
  ref_row_writer_if.master  wr,
  output logic              BUSY,
  output logic              DONE
);
  row_state_e        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-4:0] r_base;
  logic [7:0]        r_shadow [ROW_LEN];
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_busy;
  logic              r_done;

  logic [7:0]        w_recon [ROW_LEN];
  logic [IDX_W-1:0]  w_idx_nxt;

  assign w_recon[0] = RECON0;
  assign w_recon[1] = RECON1;
  assign w_recon[2] = RECON2;
  assign w_recon[3] = RECON3;
  assign w_recon[4] = RECON4;
  assign w_recon[5] = RECON5;
  assign w_recon[6] = RECON6;
  assign w_recon[7] = RECON7;
  assign w_idx_nxt  = r_idx + IDX_W'(1);

  // Outputs are precomputed one edge ahead so every output is a flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_base  <= '0;
      for (int i = 0; i < ROW_LEN; i++) r_shadow[i] <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (FLUSH) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            for (int i = 0; i < ROW_LEN; i++) r_shadow[i] <= w_recon[i];
            r_base  <= BLK_X;
            r_idx   <= '0;
            r_state <= ST_SEND;
            r_valid <= 1'b1;
            r_addr  <= {BLK_X, IDX_W'(0)};
            r_data  <= RECON0;
            r_busy  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (wr.WR_READY) begin
            if (r_idx == IDX_W'(ROW_LEN - 1)) begin
              r_state <= ST_FIN;
              r_valid <= 1'b0;
              r_addr  <= '0;
              r_data  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_idx  <= w_idx_nxt;
              r_addr <= {r_base, w_idx_nxt};
              r_data <= r_shadow[w_idx_nxt];
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_valid <= 1'b0;
          r_addr  <= '0;
          r_data  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign wr.WR_VALID = r_valid;
  assign wr.WR_ADDR  = r_addr;
  assign wr.WR_DATA  = r_data;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
endmodule

// File: tb/tb_ref_row_writer.sv
// Scenario bench for ref_row_writer against a queue-based row model.
module tb_ref_row_writer;
  localparam int AW = 9;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          FLUSH = 1'b0;
  logic          START = 1'b0;
  logic [AW-4:0] BLK_X = '0;
  logic [7:0]    rc [8];
  logic          BUSY, DONE;

  ref_row_writer_if #(.ADDR_W(AW)) wr_if ();

  ref_row_writer #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .START(START), .BLK_X(BLK_X),
    .RECON0(rc[0]), .RECON1(rc[1]), .RECON2(rc[2]), .RECON3(rc[3]),
    .RECON4(rc[4]), .RECON5(rc[5]), .RECON6(rc[6]), .RECON7(rc[7]),
    .wr(wr_if), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int errs = 0;
  int checks = 0;

  // Model: a row is a queue of pending (address, byte) pairs; after the last
  // byte is accepted there is one DONE cycle before the block is free again.
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } xfer_t;
  xfer_t m_q[$];
  bit    m_fin = 1'b0;

  task automatic model_step(input bit st, input bit fl, input bit rs, input bit rdy);
    if (rs || fl) begin
      m_q.delete();
      m_fin = 1'b0;
    end else if (m_q.size() > 0) begin
      if (rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_fin = 1'b1;
      end
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (st) begin
      for (int i = 0; i < 8; i++) begin
        xfer_t x;
        x.a = AW'(int'(BLK_X) * 8 + i);
        x.d = rc[i];
        m_q.push_back(x);
      end
    end
  endtask

  function automatic logic [19:0] expv();
    if (m_q.size() > 0) return {1'b1, m_q[0].a, m_q[0].d, 1'b1, 1'b0};
    return {1'b0, 9'd0, 8'd0, m_fin, m_fin};
  endfunction

  function automatic logic [19:0] obsv();
    return {wr_if.WR_VALID, wr_if.WR_ADDR, wr_if.WR_DATA, BUSY, DONE};
  endfunction

  // Drive one cycle's inputs, advance the model, then land just after the edge.
  task automatic cyc(input bit st, input bit fl, input bit rs, input bit rdy);
    START = st; FLUSH = fl; RST = rs; wr_if.WR_READY = rdy;
    model_step(st, fl, rs, rdy);
    @(posedge CLK);
    #1;
  endtask

  task automatic set_row(input logic [AW-4:0] bx, input int first);
    BLK_X = bx;
    for (int i = 0; i < 8; i++) rc[i] = 8'(first + i);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 1);
      checks++;
      if (obsv() !== 20'd0) begin
        errs++; $display("FAIL reset k=%0d got=%h exp=%h", k, obsv(), 20'd0);
      end
    end
  endtask

  task automatic test_basic();
    set_row(6'd5, 10);
    for (int k = 0; k <= 11; k++) begin
      cyc(k == 0, 0, 0, 1);
      checks++;
      if (obsv() !== expv()) begin
        errs++; $display("FAIL basic c=%0d got=%h exp=%h", k + 1, obsv(), expv());
      end
      if (k + 1 >= 1 && k + 1 <= 8) begin
        checks++;
        if (wr_if.WR_ADDR !== AW'(39 + k + 1) || wr_if.WR_DATA !== 8'(9 + k + 1)) begin
          errs++; $display("FAIL basic_byte c=%0d got=%0d/%0d exp=%0d/%0d", k + 1,
                           wr_if.WR_ADDR, wr_if.WR_DATA, 39 + k + 1, 9 + k + 1);
        end
      end
      checks++;
      if (DONE !== (k + 1 == 9)) begin
        errs++; $display("FAIL basic_done c=%0d got=%b exp=%b", k + 1, DONE, k + 1 == 9);
      end
    end
  endtask

  task automatic test_stall();
    set_row(6'd5, 10);
    for (int k = 0; k <= 13; k++) begin
      cyc(k == 0, 0, 0, !(k >= 3 && k <= 5));
      checks++;
      if (obsv() !== expv()) begin
        errs++; $display("FAIL stall c=%0d got=%h exp=%h", k + 1, obsv(), expv());
      end
      if (k + 1 >= 3 && k + 1 <= 6) begin
        checks++;
        if (wr_if.WR_VALID !== 1'b1 || wr_if.WR_ADDR !== 9'd42 || wr_if.WR_DATA !== 8'd12) begin
          errs++; $display("FAIL stall_hold c=%0d got=%0d/%0d exp=42/12", k + 1,
                           wr_if.WR_ADDR, wr_if.WR_DATA);
        end
      end
      checks++;
      if (DONE !== (k + 1 == 12)) begin
        errs++; $display("FAIL stall_done c=%0d got=%b exp=%b", k + 1, DONE, k + 1 == 12);
      end
    end
  endtask

  task automatic test_ignored_start();
    set_row(6'd5, 10);
    for (int k = 0; k <= 14; k++) begin
      if (k == 4) set_row(6'd20, 99);
      cyc(k == 0 || k == 4, 0, 0, 1);
      checks++;
      if (obsv() !== expv()) begin
        errs++; $display("FAIL ign_start c=%0d got=%h exp=%h", k + 1, obsv(), expv());
      end
      if (k + 1 >= 5 && k + 1 <= 8) begin
        checks++;
        if (wr_if.WR_DATA !== 8'(9 + k + 1) || wr_if.WR_ADDR !== AW'(39 + k + 1)) begin
          errs++; $display("FAIL ign_start_byte c=%0d got=%0d/%0d exp=%0d/%0d", k + 1,
                           wr_if.WR_ADDR, wr_if.WR_DATA, 39 + k + 1, 9 + k + 1);
        end
      end
    end
  endtask

  task automatic test_flush();
    set_row(6'd5, 10);
    for (int k = 0; k <= 16; k++) begin
      if (k == 5) set_row(6'd9, 50);
      cyc(k == 0 || k == 5, k == 4, 0, 1);
      checks++;
      if (obsv() !== expv()) begin
        errs++; $display("FAIL flush c=%0d got=%h exp=%h", k + 1, obsv(), expv());
      end
      if (k + 1 == 5) begin
        checks++;
        if (wr_if.WR_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
          errs++; $display("FAIL flush_idle got=%b%b%b exp=000", wr_if.WR_VALID, BUSY, DONE);
        end
      end
      if (k + 1 == 6) begin
        checks++;
        if (wr_if.WR_ADDR !== 9'd72 || wr_if.WR_DATA !== 8'd50) begin
          errs++; $display("FAIL flush_restart got=%0d/%0d exp=72/50", wr_if.WR_ADDR, wr_if.WR_DATA);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_row(6'd5, 10);
    for (int k = 0; k <= 14; k++) begin
      if (k == 4) set_row(6'd33, 200);
      cyc(k == 0 || k == 4, 0, k == 3, 1);
      checks++;
      if (obsv() !== expv()) begin
        errs++; $display("FAIL rst_mid c=%0d got=%h exp=%h", k + 1, obsv(), expv());
      end
      if (k + 1 == 4) begin
        checks++;
        if (obsv() !== 20'd0) begin
          errs++; $display("FAIL rst_mid_zero got=%h exp=0", obsv());
        end
      end
      if (k + 1 == 5) begin
        checks++;
        if (wr_if.WR_ADDR !== 9'd264 || wr_if.WR_DATA !== 8'd200) begin
          errs++; $display("FAIL rst_mid_restart got=%0d/%0d exp=264/200", wr_if.WR_ADDR, wr_if.WR_DATA);
        end
      end
    end
  endtask

  task automatic test_max_addr();
    BLK_X = 6'd63;
    for (int i = 0; i < 8; i++) rc[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k <= 10; k++) begin
      cyc(k == 0, 0, 0, 1);
      checks++;
      if (obsv() !== expv()) begin
        errs++; $display("FAIL max_addr c=%0d got=%h exp=%h", k + 1, obsv(), expv());
      end
      if (k + 1 >= 1 && k + 1 <= 8) begin
        checks++;
        if (wr_if.WR_ADDR !== AW'(503 + k + 1)) begin
          errs++; $display("FAIL max_addr_val c=%0d got=%0d exp=%0d", k + 1, wr_if.WR_ADDR, 503 + k + 1);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        BLK_X = 6'($urandom_range(0, 63));
        for (int i = 0; i < 8; i++) rc[i] = 8'($urandom_range(0, 255));
      end
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3,
          $urandom_range(0, 199) < 2, $urandom_range(0, 9) < 6);
      checks++;
      if (obsv() !== expv()) begin
        errs++; $display("FAIL random k=%0d got=%h exp=%h", k, obsv(), expv());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rc[i] = 8'd0;
    wr_if.WR_READY = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_ignored_start();
    test_flush();
    test_reset_mid();
    test_max_addr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
